// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, field widths and MIPS funct/opcode
// constants used by the issue stage and the ALU itself.
package alu_pkg;

   localparam int unsigned OP_W    = 4;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned OPSEL_W = OP_W + SHAMT_W;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_NOR  = 4'b0100,
      OP_DIV  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_SLLV = 4'b1000,
      OP_SRLV = 4'b1001,
      OP_SRAV = 4'b1010,
      OP_SLL  = 4'b1011,
      OP_SRL  = 4'b1100,
      OP_SRA  = 4'b1101
   } alu_opcode_e;

   // Main-control ALU classes
   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;

   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_SLTI = 6'b001010;
   localparam logic [5:0] OPC_ANDI = 6'b001100;
   localparam logic [5:0] OPC_ORI  = 6'b001101;
   localparam logic [5:0] OPC_XORI = 6'b001110;

   typedef struct packed {
      logic [31:0]        op_a;
      logic [31:0]        op_b;
      logic [OPSEL_W-1:0] op_sel;
      logic               illegal;
      logic               div_zero;
   } issue_entry_t;

   function automatic logic [OPSEL_W-1:0] pack_sel(input alu_opcode_e op,
                                                   input logic [SHAMT_W-1:0] shamt);
      return {shamt, op};
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU decode: maps main-control class plus funct/opcode to an
// op select and the operand pair presented to the ALU.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0]        instr,
   input  logic [1:0]         alu_op,
   input  logic [31:0]        rs_val,
   input  logic [31:0]        rt_val,
   output logic [31:0]        op_a,
   output logic [31:0]        op_b,
   output logic [OPSEL_W-1:0] op_sel,
   output logic               illegal,
   output logic               div_zero
);

   alu_opcode_e        op;
   logic [SHAMT_W-1:0] shamt;
   logic [31:0]        imm_s;
   logic [31:0]        imm_z;
   logic               unused_bits;

   assign imm_s       = {{16{instr[15]}}, instr[15:0]};
   assign imm_z       = {16'h0000, instr[15:0]};
   assign unused_bits = ^instr[25:16];

   always_comb begin
      op      = OP_ADD;
      shamt   = '0;
      op_a    = rs_val;
      op_b    = rt_val;
      illegal = 1'b0;
      case (alu_op)
         ALUOP_MEM: op_b = imm_s;
         ALUOP_BR:  op = OP_SUB;
         ALUOP_RTYPE: begin
            case (instr[5:0])
               FN_AND:          op = OP_AND;
               FN_OR:           op = OP_OR;
               FN_ADD, FN_ADDU: op = OP_ADD;
               FN_SUB, FN_SUBU: op = OP_SUB;
               FN_SLT:          op = OP_SLT;
               FN_XOR:          op = OP_XOR;
               FN_NOR:          op = OP_NOR;
               FN_DIV:          op = OP_DIV;
               // Variable shifts: value to shift is rt, amount comes from rs
               FN_SLLV: begin op = OP_SLLV; op_a = rt_val; op_b = rs_val; end
               FN_SRLV: begin op = OP_SRLV; op_a = rt_val; op_b = rs_val; end
               FN_SRAV: begin op = OP_SRAV; op_a = rt_val; op_b = rs_val; end
               FN_SLL: begin
                  op = OP_SLL; op_a = rt_val; op_b = '0; shamt = instr[10:6];
               end
               FN_SRL: begin
                  op = OP_SRL; op_a = rt_val; op_b = '0; shamt = instr[10:6];
               end
               FN_SRA: begin
                  op = OP_SRA; op_a = rt_val; op_b = '0; shamt = instr[10:6];
               end
               default: illegal = 1'b1;
            endcase
         end
         ALUOP_ITYPE: begin
            case (instr[31:26])
               OPC_ADDI: op_b = imm_s;
               OPC_SLTI: begin op = OP_SLT; op_b = imm_s; end
               OPC_ANDI: begin op = OP_AND; op_b = imm_z; end
               OPC_ORI:  begin op = OP_OR;  op_b = imm_z; end
               OPC_XORI: begin op = OP_XOR; op_b = imm_z; end
               default: begin illegal = 1'b1; op_b = imm_s; end
            endcase
         end
      endcase
   end

   assign op_sel   = pack_sel(op, shamt);
   assign div_zero = (op == OP_DIV) && (rt_val == '0);

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and buffers the result in a
// two-entry (output register + skid) valid/ready queue with an illegal counter.
module alu_issue
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic [1:0]         alu_op,
   input  logic [31:0]        rs_val,
   input  logic [31:0]        rt_val,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        op_a,
   output logic [31:0]        op_b,
   output logic [OPSEL_W-1:0] op_sel,
   output logic               illegal,
   output logic               div_zero,
   output logic [15:0]        illegal_cnt
);

   issue_entry_t dec;
   issue_entry_t out_q, out_nxt;
   issue_entry_t skid_q, skid_nxt;
   logic         out_valid_q, out_valid_nxt;
   logic         skid_valid_q, skid_valid_nxt;
   logic         in_ready_q;
   logic [15:0]  cnt_q;
   logic         acc;
   logic         deq;

   alu_decode u_decode (
      .instr    (instr),
      .alu_op   (alu_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .op_a     (dec.op_a),
      .op_b     (dec.op_b),
      .op_sel   (dec.op_sel),
      .illegal  (dec.illegal),
      .div_zero (dec.div_zero)
   );

   assign acc = in_valid && in_ready_q && !flush;
   assign deq = out_valid_q && out_ready;

   always_comb begin
      out_nxt        = out_q;
      out_valid_nxt  = out_valid_q;
      skid_nxt       = skid_q;
      skid_valid_nxt = skid_valid_q;
      if (flush) begin
         out_valid_nxt  = 1'b0;
         skid_valid_nxt = 1'b0;
      end else if (!out_valid_q || deq) begin
         // Output register frees up: refill from skid first to keep order
         if (skid_valid_q) begin
            out_nxt        = skid_q;
            out_valid_nxt  = 1'b1;
            skid_valid_nxt = acc;
            if (acc) skid_nxt = dec;
         end else begin
            out_valid_nxt = acc;
            if (acc) out_nxt = dec;
         end
      end else if (acc) begin
         skid_nxt       = dec;
         skid_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_nxt;
         skid_q       <= skid_nxt;
         out_valid_q  <= out_valid_nxt;
         skid_valid_q <= skid_valid_nxt;
         in_ready_q   <= !skid_valid_nxt;
         if (acc && dec.illegal && (cnt_q != '1)) cnt_q <= cnt_q + 16'd1;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign op_a        = out_q.op_a;
   assign op_b        = out_q.op_b;
   assign op_sel      = out_q.op_sel;
   assign illegal     = out_q.illegal;
   assign div_zero    = out_q.div_zero;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, hand sequences for
// backpressure/flush/reset, and randomized traffic against a queue model.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [1:0]  alu_op = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [8:0]  op_sel;
   logic        illegal;
   logic        div_zero;
   logic [15:0] illegal_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .alu_op      (alu_op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_sel      (op_sel),
      .illegal     (illegal),
      .div_zero    (div_zero),
      .illegal_cnt (illegal_cnt)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [8:0]  sel;
      logic        ill;
      logic        dz;
   } exp_t;

   typedef struct {
      logic [1:0]  aop;
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] a;
      logic [31:0] b;
      logic [8:0]  sel;
      logic        ill;
      logic        dz;
   } vec_t;

   exp_t        q[$];
   logic [15:0] mcnt = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference decode straight from the op-code tables
   function automatic exp_t ref_decode(input logic [1:0] aop, input logic [31:0] ins,
                                       input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      int          code;
      logic [4:0]  sh;
      logic [31:0] sx;
      logic [31:0] zx;
      sx    = {{16{ins[15]}}, ins[15:0]};
      zx    = {16'h0000, ins[15:0]};
      code  = 2;
      sh    = 5'd0;
      e.a   = rs;
      e.b   = rt;
      e.ill = 1'b0;
      if (aop == 2'd0) e.b = sx;
      else if (aop == 2'd1) code = 6;
      else if (aop == 2'd2) begin
         case (ins[5:0])
            6'h24: code = 0;   6'h25: code = 1;
            6'h20, 6'h21: code = 2;
            6'h22, 6'h23: code = 6;
            6'h2A: code = 7;   6'h26: code = 3;
            6'h27: code = 4;   6'h1A: code = 5;
            6'h04: code = 8;   6'h06: code = 9;   6'h07: code = 10;
            6'h00: code = 11;  6'h02: code = 12;  6'h03: code = 13;
            default: code = -1;
         endcase
         if (code < 0) begin e.ill = 1'b1; code = 2; end
         if (code >= 8 && code <= 10) begin e.a = rt; e.b = rs; end
         if (code >= 11) begin e.a = rt; e.b = 0; sh = ins[10:6]; end
      end else begin
         case (ins[31:26])
            6'h08: e.b = sx;
            6'h0A: begin code = 7; e.b = sx; end
            6'h0C: begin code = 0; e.b = zx; end
            6'h0D: begin code = 1; e.b = zx; end
            6'h0E: begin code = 3; e.b = zx; end
            default: begin e.ill = 1'b1; e.b = sx; end
         endcase
      end
      e.sel = {sh, 4'(code)};
      e.dz  = (code == 5) && (rt == 0);
      return e;
   endfunction

   // One clock: advance model from current inputs, then compare after the edge
   task automatic cycle();
      bit   acc;
      exp_t e;
      acc = in_valid && (q.size() < 2) && !flush;
      e   = ref_decode(alu_op, instr, rs_val, rt_val);
      if (flush) q.delete();
      else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (e.ill && mcnt != 16'hFFFF) mcnt++;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
      if (q.size() > 0) begin
         chk("op_a", op_a, q[0].a);
         chk("op_b", op_b, q[0].b);
         chk("op_sel", 32'(op_sel), 32'(q[0].sel));
         chk("illegal", 32'(illegal), 32'(q[0].ill));
         chk("div_zero", 32'(div_zero), 32'(q[0].dz));
      end
   endtask

   task automatic drive(input vec_t v, input logic vld);
      alu_op   = v.aop;
      instr    = v.ins;
      rs_val   = v.rs;
      rt_val   = v.rt;
      in_valid = vld;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_cnt"}, 32'(illegal_cnt), 32'd0);
      chk({tag, "_op_a"}, op_a, 32'd0);
      chk({tag, "_op_sel"}, 32'(op_sel), 32'd0);
      chk({tag, "_flags"}, 32'({illegal, div_zero}), 32'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      flush    = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_values("reset");
      q.delete();
      mcnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t        tbl[13];
   logic [5:0]  legal_fn[16];
   logic [5:0]  legal_opc[5];
   vec_t        v;

   initial begin
      tbl[0]  = '{2'd2, 32'h0000_0020, 32'd5, 32'd7, 32'd5, 32'd7, 9'h002, 1'b0, 1'b0};
      tbl[1]  = '{2'd2, 32'h0000_00C3, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd0, 9'h03D, 1'b0, 1'b0};
      tbl[2]  = '{2'd3, 32'h3400_FFFF, 32'd1, 32'd2, 32'd1, 32'h0000_FFFF, 9'h001, 1'b0, 1'b0};
      tbl[3]  = '{2'd3, 32'h2000_FFFF, 32'd1, 32'd2, 32'd1, 32'hFFFF_FFFF, 9'h002, 1'b0, 1'b0};
      tbl[4]  = '{2'd2, 32'h0000_001A, 32'd9, 32'd0, 32'd9, 32'd0, 9'h005, 1'b0, 1'b1};
      tbl[5]  = '{2'd2, 32'h0000_001A, 32'd9, 32'd3, 32'd9, 32'd3, 9'h005, 1'b0, 1'b0};
      tbl[6]  = '{2'd0, 32'h0000_8000, 32'h100, 32'd3, 32'h100, 32'hFFFF_8000, 9'h002, 1'b0, 1'b0};
      tbl[7]  = '{2'd1, 32'h1234_5678, 32'd10, 32'd4, 32'd10, 32'd4, 9'h006, 1'b0, 1'b0};
      tbl[8]  = '{2'd2, 32'h0000_07C4, 32'd4, 32'hF, 32'hF, 32'd4, 9'h008, 1'b0, 1'b0};
      tbl[9]  = '{2'd2, 32'h0000_003F, 32'd6, 32'd8, 32'd6, 32'd8, 9'h002, 1'b1, 1'b0};
      tbl[10] = '{2'd3, 32'h2800_8001, 32'd2, 32'd0, 32'd2, 32'hFFFF_8001, 9'h007, 1'b0, 1'b0};
      tbl[11] = '{2'd2, 32'h0000_0027, 32'd1, 32'd2, 32'd1, 32'd2, 9'h004, 1'b0, 1'b0};
      tbl[12] = '{2'd2, 32'h0000_07C2, 32'd3, 32'hABCD, 32'hABCD, 32'd0, 9'h1FC, 1'b0, 1'b0};
      legal_fn  = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h26,
                    6'h27, 6'h1A, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03};
      legal_opc = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

      repeat (2) @(negedge clk);
      do_reset();

      // Directed vectors streamed back-to-back with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i], 1'b1);
         cycle();
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("tbl%0d_a", i), op_a, tbl[i].a);
         chk($sformatf("tbl%0d_b", i), op_b, tbl[i].b);
         chk($sformatf("tbl%0d_sel", i), 32'(op_sel), 32'(tbl[i].sel));
         chk($sformatf("tbl%0d_flags", i), 32'({illegal, div_zero}), 32'({tbl[i].ill, tbl[i].dz}));
      end
      in_valid = 1'b0;
      cycle();

      // Backpressure: two accepted, third refused, outputs held, drain in order
      do_reset();
      out_ready = 1'b0;
      drive(tbl[0], 1'b1); cycle();
      drive(tbl[1], 1'b1); cycle();
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      drive(tbl[2], 1'b1); cycle();
      chk("bp_hold_a", op_a, tbl[0].a);
      chk("bp_hold_sel", 32'(op_sel), 32'(tbl[0].sel));
      chk("bp_in_ready_still", 32'(in_ready), 32'd0);
      in_valid = 1'b0; out_ready = 1'b1; cycle();
      chk("bp_second_sel", 32'(op_sel), 32'(tbl[1].sel));
      chk("bp_second_a", op_a, tbl[1].a);
      cycle();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Illegal counting, then flush dropping a same-cycle input
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(tbl[9], 1'b1);
         cycle();
         chk($sformatf("ill%0d_flag", i), 32'(illegal), 32'd1);
      end
      chk("ill_cnt3", 32'(illegal_cnt), 32'd3);
      out_ready = 1'b0;
      flush = 1'b1; drive(tbl[9], 1'b1); cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_cnt", 32'(illegal_cnt), 32'd3);

      // Async reset with a full buffer
      out_ready = 1'b0;
      drive(tbl[4], 1'b1); cycle();
      drive(tbl[5], 1'b1); cycle();
      in_valid = 1'b0;
      chk("full_before_rst", 32'(in_ready), 32'd0);
      chk("full_dz", 32'(div_zero), 32'd1);
      do_reset();

      // Randomized traffic against the queue model
      for (int n = 0; n < 1500; n++) begin
         v.aop = 2'($urandom_range(0, 3));
         v.ins = $urandom;
         if (v.aop == 2'd2) begin
            if ($urandom_range(0, 9) != 0) v.ins[5:0] = legal_fn[$urandom_range(0, 15)];
         end else if (v.aop == 2'd3) begin
            v.ins[31:26] = legal_opc[$urandom_range(0, 4)];
         end
         v.rs = $urandom;
         v.rt = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
         drive(v, 1'($urandom_range(0, 9) < 7));
         out_ready = 1'($urandom_range(0, 9) < 6);
         flush     = 1'($urandom_range(0, 32) == 0);
         cycle();
      end
      in_valid = 1'b0;
      flush    = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  upstream instruction/operands valid.
REQ-004 SHALL have ports: in_ready  out  1  block can accept this cycle; registered.
REQ-005 SHALL have ports: instr  in  32  MIPS instruction word; alu_op  in  2  main-control ALU class.
REQ-006 SHALL have ports: rs_val, rt_val  in  32 each  register-file read data.
REQ-007 SHALL have ports: flush  in  1  synchronous drop of all buffered entries.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1  ALU-stage handshake.
REQ-009 SHALL have ports: op_a, op_b  out  32; op_sel  out  9  ALU operation select: [3:0] op code, [8:4] shamt.
REQ-010 SHALL have ports: illegal, div_zero  out  1 each  per-entry flags; illegal_cnt  out  16  saturating count.

Function
REQ-011 Op codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, DIV 0101, SUB 0110, SLT 0111, SLLV 1000, SRLV 1001, SRAV 1010, SLL 1011, SRL 1100, SRA 1101.
REQ-012 alu_op 00 SHALL decode ADD, op_a=rs_val, op_b=sign-extended instr[15:0].
REQ-013 alu_op 01 SHALL decode SUB, op_a=rs_val, op_b=rt_val.
REQ-014 alu_op 10 SHALL decode funct instr[5:0]: 100100 AND, 100101 OR, 100000/100001 ADD, 100010/100011 SUB, 101010 SLT, 100110 XOR, 100111 NOR, 011010 DIV, 000100 SLLV, 000110 SRLV, 000111 SRAV, 000000 SLL, 000010 SRL, 000011 SRA; op_a=rs_val, op_b=rt_val except as REQ-016/017.
REQ-015 alu_op 11 SHALL decode opcode instr[31:26]: 001000 ADD and 001010 SLT (sign-extended imm), 001100 AND, 001101 OR, 001110 XOR (zero-extended imm); op_a=rs_val.
REQ-016 SLLV/SRLV/SRAV SHALL present op_a=rt_val, op_b=rs_val; op_sel[8:4]=0.
REQ-017 SLL/SRL/SRA SHALL present op_a=rt_val, op_b=0, op_sel[8:4]=instr[10:6]; all other ops op_sel[8:4]=0.
REQ-018 Undecodable funct/opcode SHALL produce op code ADD, illegal=1, and increment illegal_cnt on acceptance, saturating at 16'hFFFF.
REQ-019 DIV with rt_val==0 SHALL set div_zero=1 with op code still DIV; div_zero=0 otherwise.
REQ-020 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-021 Buffer SHALL be two entries (output register + skid); order preserved; latency 1 cycle accept-to-out_valid when empty.
REQ-022 in_ready SHALL be 1 iff skid entry empty; full throughput when out_ready held 1.
REQ-023 Outputs SHALL hold stable while out_valid&&!out_ready.
REQ-024 flush SHALL clear both entries next cycle, drop any same-cycle input, set in_ready=1; flush overrides simultaneous accept/output transfer; illegal_cnt not incremented by dropped input.
REQ-025 Simultaneous accept and output transfer with skid empty SHALL load new entry directly into the output register.

Reset
REQ-026 rst_n low SHALL immediately force out_valid=0, in_ready=1, skid empty, illegal_cnt=0, op_a=op_b=0, op_sel=0, illegal=div_zero=0.
REQ-027 Reset mid-transfer SHALL discard all buffered entries; first accept possible on first clk after rst_n release.

Structure
REQ-028 Op-code constants, field widths (op 4, shamt 5, op_sel 9) and funct/opcode constants SHALL live in shared package alu_pkg, also used by the ALU.
REQ-029 Decode SHALL be a combinational sub-module alu_decode (instr, alu_op, rs_val, rt_val -> op_a, op_b, op_sel, illegal, div_zero); alu_issue holds buffering and counter.

Verification
REQ-030 alu_op=10, funct 100000, rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, op_sel=9'h002, op_a=5, op_b=7.
REQ-031 SRA, instr[10:6]=3, rt=32'h8000_0000 -> op_a=32'h8000_0000, op_sel=9'h03D.
REQ-032 alu_op=11, ORI imm 16'hFFFF -> op_b=32'h0000_FFFF; ADDI imm 16'hFFFF -> op_b=32'hFFFF_FFFF.
REQ-033 out_ready=0, three back-to-back inputs -> two accepted, in_ready=0 on third, outputs stable; out_ready=1 -> entries in order.
REQ-034 Funct 111111 accepted 3 times -> illegal=1 each, illegal_cnt=3; flush with in_valid same cycle -> out_valid=0 next cycle, count unchanged.
REQ-035 DIV with rt=0 -> div_zero=1, op_sel=9'h005; rst_n asserted with full buffer -> out_valid=0, in_ready=1 immediately.
